fp_sub_seq: RTL and testbench
=============================

// Module: fp_sub_seq
// PURPOSE
//  Multi-cycle IEEE-754 single-precision subtractor, result = A - B; the inverse-operation companion to the combinational adder.
//  Handles both signs, aligns by iterative right shift, normalises by iterative left shift, then packs.
//  Sits on the FP datapath behind a valid/ready operand stream and drives a valid/ready result stream.
// PARAMETERS
//  MAX_ALIGN  26  saturation of alignment shift count; larger exponent gaps shift the smaller mantissa to sticky-only
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   operands a/b valid
//  in_ready   out  1   block can accept operands (high only in IDLE)
//  a          in   32  minuend, IEEE-754 single
//  b          in   32  subtrahend, IEEE-754 single
//  out_valid  out  1   result/flags valid
//  out_ready  in   1   downstream accepts result
//  result     out  32  A - B, IEEE-754 single
//  invalid    out  1   NaN input or inf - inf (same sign)
//  overflow   out  1   result exponent reached 255
//  zero       out  1   result is +0/-0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, invalid=overflow=zero=0; in-flight op discarded.
//  Accept on in_valid&&in_ready; a/b captured, in_ready drops the next cycle.
//  Unpack: exp==0 -> operand is zero (denormals flushed); else mantissa {1,frac}; B sign inverted; working width 28b = carry+24+guard,round,sticky.
//  FSM: IDLE -> ALIGN -> OP -> NORM -> PACK -> DONE -> IDLE.
//   IDLE: on accept, special-case check; special -> DONE next cycle directly.
//   ALIGN: larger-exponent operand is reference; smaller mantissa >>1 per cycle, OR shifted-out bits into sticky; min(|ea-eb|,MAX_ALIGN) cycles (0 cycles: pass straight to OP).
//   OP: 1 cycle; effective signs equal -> magnitude add, else subtract smaller magnitude from larger, sign of larger; equal magnitudes -> +0.
//   NORM: carry set -> >>1, exp+1 (1 cycle); else <<1, exp-1 per cycle until bit 26 set; exp reaching 0 -> flush to +0; zero mantissa -> skip to PACK.
//   PACK: 1 cycle; truncate guard bits (see CONFIGURATION); exp>=255 -> +/-inf, overflow=1.
//   DONE: out_valid=1; result/flags held stable until out_ready; out_valid&&out_ready -> IDLE, in_ready=1 next cycle.
//  Latency accept->out_valid = 1 + align + 1 + norm + 1 cycles; special cases 1 cycle. No back-to-back overlap.
//  Special cases: any NaN -> 0x7FC00000, invalid=1; inf-inf same sign -> 0x7FC00000, invalid=1; A inf -> A; B inf -> B with sign flipped; both zero -> 0x00000000 (zero=1) unless A=-0,B=+0 -> 0x80000000.
//  Flags are valid only with out_valid; cleared on leaving DONE.
//  a/b changes while busy are ignored; reset mid-operation returns to IDLE with outputs at reset values.
// CONFIGURATION
//  FP_SUB_ROUND_EN defined: PACK rounds to nearest-even using guard/round/sticky; mantissa carry-out renormalises (exp+1), may overflow to inf; PACK remains 1 cycle.
//  FP_SUB_ROUND_EN undefined: round-toward-zero (guard bits discarded).
// TESTING
//  1 a=0x40400000,b=0x3F800000 -> result=0x40000000, 1 align cycle, flags 0.
//  2 a=0x3F800000,b=0x3F800000 -> 0x00000000, zero=1.
//  3 a=0x3F800000,b=0xBF800000 -> 0x40000000 via carry normalise.
//  4 a=0x3F800001,b=0x3F800000 -> 0x34000000 after 23 NORM cycles.
//  5 a=0x7F800000,b=0x7F800000 -> 0x7FC00000, invalid=1, 1-cycle latency; a=0x7F800000,b=0x3F800000 -> 0x7F800000.
//  6 a=0x3F800000,b=0x33000000 -> 0x3F7FFFFF without FP_SUB_ROUND_EN, 0x3F800000 with it.
//  7 out_ready low 5 cycles in DONE -> result stable, in_ready=0; rst_n pulsed low mid-NORM -> out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (result = a - b) with valid/ready streams.
// Define FP_SUB_ROUND_EN for round-to-nearest-even in PACK; otherwise results truncate toward zero.
module fp_sub_seq #(
    parameter int MAX_ALIGN = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        invalid,
    output logic        overflow,
    output logic        zero
);
    localparam int CW = $clog2(MAX_ALIGN + 1);
`ifdef FP_SUB_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, ALIGN, OP, NORM, PACK, DONE} state_t;

    state_t        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   result_q, result_d;
    logic          invalid_q, invalid_d;
    logic          overflow_q, overflow_d;
    logic          zero_q, zero_d;
    logic [27:0]   xm_q, xm_d, ym_q, ym_d;
    logic          xs_q, xs_d, ys_q, ys_d;
    logic [8:0]    exp_q, exp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Returns {exponent[8:0], mantissa[23:0] incl. hidden bit}; hidden bit clear means zero.
    function automatic logic [32:0] round_pack(input logic [26:0] m, input logic [8:0] e);
        logic [24:0] r;
        logic        up;
        logic [8:0]  eo;
        up = ROUND_EN & m[2] & (m[3] | m[1] | m[0]);
        r  = {1'b0, m[26:3]} + {24'd0, up};
        eo = e;
        if (r[24]) begin
            r  = {1'b0, r[24:1]};
            eo = e + 9'd1;
        end
        return {eo, r[23:0]};
    endfunction

    function automatic logic [CW-1:0] sat_shift(input logic [7:0] d);
        return (int'(d) > MAX_ALIGN) ? CW'(MAX_ALIGN) : CW'(d);
    endfunction

    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, bs_eff;
    logic [27:0] am, bm;

    assign a_zero = (a[30:23] == 8'h00);
    assign b_zero = (b[30:23] == 8'h00);
    assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign am     = a_zero ? 28'd0 : {2'b01, a[22:0], 3'b000};
    assign bm     = b_zero ? 28'd0 : {2'b01, b[22:0], 3'b000};
    assign bs_eff = ~b[31];

    logic        spec_hit, spec_inv, spec_zero;
    logic [31:0] spec_res;

    always_comb begin
        spec_hit  = 1'b1;
        spec_res  = 32'd0;
        spec_inv  = 1'b0;
        spec_zero = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] == b[31]))) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_res = a;
        end else if (b_inf) begin
            spec_res = {bs_eff, b[30:0]};
        end else if (a_zero && b_zero) begin
            spec_res  = {a[31] & ~b[31], 31'd0};
            spec_zero = 1'b1;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Effective-sign magnitude add/subtract; equal magnitudes cancel to +0.
    logic [27:0] sum_w;
    logic        sgn_w;
    always_comb begin
        if (xs_q == ys_q) begin
            sum_w = xm_q + ym_q;
            sgn_w = xs_q;
        end else if (xm_q > ym_q) begin
            sum_w = xm_q - ym_q;
            sgn_w = xs_q;
        end else if (ym_q > xm_q) begin
            sum_w = ym_q - xm_q;
            sgn_w = ys_q;
        end else begin
            sum_w = 28'd0;
            sgn_w = 1'b0;
        end
    end

    logic [32:0] pk_w;
    assign pk_w = round_pack(xm_q[26:0], exp_q);

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        invalid_d   = invalid_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        xm_d        = xm_q;
        ym_d        = ym_q;
        xs_d        = xs_q;
        ys_d        = ys_q;
        exp_d       = exp_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                in_ready_d = 1'b0;
                if (spec_hit) begin
                    result_d    = spec_res;
                    invalid_d   = spec_inv;
                    zero_d      = spec_zero;
                    overflow_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    if (a[30:23] >= b[30:23]) begin
                        xm_d  = am;
                        xs_d  = a[31];
                        ym_d  = bm;
                        ys_d  = bs_eff;
                        exp_d = {1'b0, a[30:23]};
                        cnt_d = sat_shift(a[30:23] - b[30:23]);
                    end else begin
                        xm_d  = bm;
                        xs_d  = bs_eff;
                        ym_d  = am;
                        ys_d  = a[31];
                        exp_d = {1'b0, b[30:23]};
                        cnt_d = sat_shift(b[30:23] - a[30:23]);
                    end
                    state_d = (cnt_d == '0) ? OP : ALIGN;
                end
            end
            ALIGN: begin
                ym_d  = {1'b0, ym_q[27:2], ym_q[1] | ym_q[0]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = OP;
            end
            OP: begin
                xm_d    = sum_w;
                xs_d    = sgn_w;
                state_d = ((sum_w == 28'd0) || (!sum_w[27] && sum_w[26])) ? PACK : NORM;
            end
            NORM: begin
                if (xm_q[27]) begin
                    xm_d    = {1'b0, xm_q[27:2], xm_q[1] | xm_q[0]};
                    exp_d   = exp_q + 9'd1;
                    state_d = PACK;
                end else if (exp_q <= 9'd1) begin
                    // Result would be denormal: flush to +0.
                    xm_d    = 28'd0;
                    xs_d    = 1'b0;
                    state_d = PACK;
                end else begin
                    xm_d  = {xm_q[26:0], 1'b0};
                    exp_d = exp_q - 9'd1;
                    if (xm_q[25]) state_d = PACK;
                end
            end
            PACK: begin
                out_valid_d = 1'b1;
                state_d     = DONE;
                if (!pk_w[23]) begin
                    result_d = 32'd0;
                    zero_d   = 1'b1;
                end else if (pk_w[32:24] >= 9'd255) begin
                    result_d   = {xs_q, 8'hFF, 23'd0};
                    overflow_d = 1'b1;
                end else begin
                    result_d = {xs_q, pk_w[31:24], pk_w[22:0]};
                end
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                invalid_d   = 1'b0;
                overflow_d  = 1'b0;
                zero_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            invalid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            invalid_q   <= invalid_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    // Datapath registers are only read after IDLE has loaded them.
    always_ff @(posedge clk) begin
        xm_q  <= xm_d;
        ym_q  <= ym_d;
        xs_q  <= xs_d;
        ys_q  <= ys_d;
        exp_q <= exp_d;
        cnt_q <= cnt_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign invalid   = invalid_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_fp_sub_seq.sv
// Self-checking bench for fp_sub_seq: directed cases plus randomized operands against an exact-arithmetic model.
`timescale 1ns/1ps
module tb_fp_sub_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic        invalid, overflow, zero;
    int          checks = 0;
    int          errors = 0;
`ifdef FP_SUB_ROUND_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    fp_sub_seq #(.MAX_ALIGN(26)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .invalid(invalid), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact reference: operands become integers scaled by 2^149, difference taken exactly,
    // then normalised, flushed below the normal range, and rounded by mode. Returns {inv,ovf,zero,result}.
    function automatic logic [34:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
        logic [299:0] vx, vy, mag, sig, rem, half;
        logic         sx, sy, s;
        int           p, e;
        if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0))
            return {3'b100, 32'h7FC00000};
        if (x[30:0] == 31'h7F800000 && y[30:0] == 31'h7F800000 && x[31] == y[31])
            return {3'b100, 32'h7FC00000};
        if (x[30:0] == 31'h7F800000) return {3'b000, x};
        if (y[30:0] == 31'h7F800000) return {3'b000, ~y[31], y[30:0]};
        if (x[30:23] == 0 && y[30:23] == 0)
            return {3'b001, (x[31] && !y[31]) ? 32'h80000000 : 32'h0};
        vx = (x[30:23] == 0) ? 300'd0 : (300'({1'b1, x[22:0]}) << (int'(x[30:23]) - 1));
        vy = (y[30:23] == 0) ? 300'd0 : (300'({1'b1, y[22:0]}) << (int'(y[30:23]) - 1));
        sx = x[31];
        sy = ~y[31];
        s  = 1'b0;
        if (sx == sy) begin mag = vx + vy; s = sx; end
        else if (vx > vy) begin mag = vx - vy; s = sx; end
        else if (vy > vx) begin mag = vy - vx; s = sy; end
        else mag = 300'd0;
        if (mag == 0) return {3'b001, 32'h0};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) return {3'b001, 32'h0};
        sig = mag >> (p - 23);
        rem = mag - (sig << (p - 23));
        if (RNE && p >= 24) begin
            half = 300'd1 << (p - 24);
            if (rem > half || (rem == half && sig[0])) sig = sig + 300'd1;
        end
        if (sig[24]) begin sig = sig >> 1; e = e + 1; end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
        return {3'b000, s, 8'(e), sig[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        case ($urandom_range(0, 9))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 2));
            3:       e = 8'($urandom_range(252, 254));
            default: e = 8'($urandom_range(90, 160));
        endcase
        return {1'($urandom), e, ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom)};
    endfunction

    function automatic logic [31:0] near_fp(input logic [31:0] x);
        int e;
        e = int'(x[30:23]) + $urandom_range(0, 4) - 2;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom), 8'(e), x[22:0] ^ 23'($urandom_range(0, 255))};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                          input int hold, input logic [31:0] er, input logic [2:0] ef, input int elat);
        int g, lat;
        @(negedge clk);
        a = ta; b = tbv; in_valid = 1'b1; out_ready = (hold == 0);
        g = 0;
        while (!in_ready && g < 100) begin @(negedge clk); g++; end
        chk({tag, " accept"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, " result"}, result, er);
        chk({tag, " flags"}, {29'd0, invalid, overflow, zero}, {29'd0, ef});
        if (elat > 0) chk({tag, " latency"}, 32'(lat), 32'(elat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " held result"}, result, er);
            chk({tag, " held in_ready"}, {31'd0, in_ready}, 32'd0);
            chk({tag, " held out_valid"}, {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " release"}, {28'd0, out_valid, in_ready, invalid | overflow, zero}, 32'h4);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [34:0] m;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 32'd0; b = 32'd0;
        #12;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flags", {29'd0, invalid, overflow, zero}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("t1 3-1", 32'h40400000, 32'h3F800000, 0, 32'h40000000, 3'b000, 4);
        run_op("t2 1-1", 32'h3F800000, 32'h3F800000, 0, 32'h00000000, 3'b001, 3);
        run_op("t3 1+1", 32'h3F800000, 32'hBF800000, 0, 32'h40000000, 3'b000, 4);
        run_op("t4 norm23", 32'h3F800001, 32'h3F800000, 0, 32'h34000000, 3'b000, 26);
        run_op("t5 inf-inf", 32'h7F800000, 32'h7F800000, 0, 32'h7FC00000, 3'b100, 1);
        run_op("t5 inf-1", 32'h7F800000, 32'h3F800000, 0, 32'h7F800000, 3'b000, 1);
        run_op("t6 round", 32'h3F800000, 32'h33000000, 0, RNE ? 32'h3F800000 : 32'h3F7FFFFF, 3'b000, 29);
        run_op("ovf", 32'h7F7FFFFF, 32'hFF7FFFFF, 0, 32'h7F800000, 3'b010, 4);
        run_op("flush", 32'h00800001, 32'h00800000, 0, 32'h00000000, 3'b001, 4);
        run_op("1-inf", 32'h3F800000, 32'h7F800000, 0, 32'hFF800000, 3'b000, 1);
        run_op("nan", 32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 3'b100, 1);
        run_op("-0-+0", 32'h80000000, 32'h00000000, 0, 32'h80000000, 3'b001, 1);
        run_op("+0--0", 32'h00000000, 32'h80000000, 0, 32'h00000000, 3'b001, 1);
        run_op("0-1 satalign", 32'h00000000, 32'h3F800000, 0, 32'hBF800000, 3'b000, 29);
        m = ref_sub(32'h3F800000, 32'h2F800000);
        run_op("sticky gap", 32'h3F800000, 32'h2F800000, 0, m[31:0], m[34:32], 30);
        run_op("t7 hold", 32'h40400000, 32'h3F800000, 5, 32'h40000000, 3'b000, 4);

        // Reset while the long normalisation of case t4 is in progress.
        @(negedge clk);
        a = 32'h3F800001; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midnorm rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midnorm rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midnorm rst result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op("post reset", 32'h3F800000, 32'hBF800000, 0, 32'h40000000, 3'b000, 4);

        for (int n = 0; n < 150; n++) begin
            ra = rnd_fp();
            rb = ($urandom_range(0, 1) == 1) ? near_fp(ra) : rnd_fp();
            m  = ref_sub(ra, rb);
            run_op($sformatf("rand%0d %h-%h", n, ra, rb), ra, rb, $urandom_range(0, 2),
                   m[31:0], m[34:32], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
